// File: rtl/phys_mem_pkg.sv
// Shared types and helpers for the banked physical memory.
// Latency: none (types and constant functions only).
// Backpressure: not applicable.
//
// Contents: FSM state enum, ceil-log2, bank/word index extraction from a byte address.
package phys_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    BEAT = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Bank number from the bank-select field starting at sel_lsb.
  function automatic logic [31:0] bank_index(input logic [31:0] addr, input int sel_lsb,
                                             input int banks);
    return (addr >> sel_lsb) & 32'(banks - 1);
  endfunction

  // Word index inside a bank; byte-offset bits [1:0] are dropped.
  function automatic logic [31:0] word_index(input logic [31:0] addr, input int bank_aw);
    return (addr >> 2) & ((32'd1 << bank_aw) - 32'd1);
  endfunction

endpackage

// File: rtl/mem_bank_ram.sv
// Single-port RAM bank with per-byte write enables and registered read data.
// Latency: read data appears one clock after addr_i; writes land on the same edge.
// Backpressure: none; always accepts one access per cycle.
//
// Ports: clk; we_i/be_i write strobe and byte mask; addr_i word address;
//        wdata_i write data; rdata_o registered read data (old contents on a write).
module mem_bank_ram #(
  parameter int DATA_W = 32,
  parameter int AW     = 7
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [AW-1:0]       addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o
);

  logic [DATA_W-1:0] mem_q [2**AW];

  // Contents are deliberately not reset: they survive a clrn pulse.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (be_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/banked_physical_memory.sv
// Banked physical memory behind a strobe/rw/ready port with wait states and wrapping bursts.
// Latency: first ready WAIT_CYCLES edges after acceptance (accepting edge counts), then 1 or BURST_LEN back-to-back beats.
// Backpressure: requester holds strobe for the whole transaction; dropping it aborts on that edge.
//
// Ports: clk, clrn (async active-low); a byte address; din write data; dout read data
//        (zero outside ready); strobe/rw/be/burst request, sampled at acceptance;
//        ready one beat per cycle; busy high from acceptance through the last beat.
module banked_physical_memory
  import phys_mem_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int BANKS        = 4,
  parameter int BANK_AW      = 7,
  parameter int BANK_SEL_LSB = 13,
  parameter int WAIT_CYCLES  = 6,
  parameter int BURST_LEN    = 4
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic [31:0]         a,
  input  logic [DATA_W-1:0]   din,
  output logic [DATA_W-1:0]   dout,
  input  logic                strobe,
  input  logic                rw,
  input  logic [DATA_W/8-1:0] be,
  input  logic                burst,
  output logic                ready,
  output logic                busy
);

  localparam int NBYTES = DATA_W / 8;
  localparam int BSEL_W = (BANKS > 1) ? clog2(BANKS) : 1;
  localparam int BEAT_W = (BURST_LEN > 1) ? clog2(BURST_LEN) : 1;
  localparam int WCNT_W = clog2(WAIT_CYCLES + 1);
  localparam logic [BANK_AW-1:0] BMASK = BANK_AW'(BURST_LEN - 1);

  if (BANK_SEL_LSB < BANK_AW + 2) begin : g_chk_sel
    $error("banked_physical_memory: BANK_SEL_LSB overlaps the word-index field");
  end
  if (WAIT_CYCLES < 2) begin : g_chk_wait
    $error("banked_physical_memory: WAIT_CYCLES must be at least 2");
  end
  if ((DATA_W % 8) != 0) begin : g_chk_dw
    $error("banked_physical_memory: DATA_W must be a multiple of 8");
  end
  if ((BURST_LEN & (BURST_LEN - 1)) != 0 || BURST_LEN > (1 << BANK_AW)) begin : g_chk_bl
    $error("banked_physical_memory: BURST_LEN must be a power of 2 not exceeding bank depth");
  end

  state_e              state_q, state_d;
  logic [WCNT_W-1:0]   wait_q, wait_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [BSEL_W-1:0]   bank_q, bank_d;
  logic [BANK_AW-1:0]  widx_q, widx_d;
  logic                rw_q, rw_d;
  logic                burst_q, burst_d;
  logic [NBYTES-1:0]   be_q, be_d;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= IDLE;
      wait_q  <= '0;
      beat_q  <= '0;
      bank_q  <= '0;
      widx_q  <= '0;
      rw_q    <= 1'b0;
      burst_q <= 1'b0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      beat_q  <= beat_d;
      bank_q  <= bank_d;
      widx_q  <= widx_d;
      rw_q    <= rw_d;
      burst_q <= burst_d;
      be_q    <= be_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    beat_d  = beat_q;
    bank_d  = bank_q;
    widx_d  = widx_q;
    rw_d    = rw_q;
    burst_d = burst_q;
    be_d    = be_q;
    case (state_q)
      IDLE: begin
        if (strobe) begin
          state_d = WAIT;
          wait_d  = WCNT_W'(1);  // the accepting edge is the first counted edge
          beat_d  = '0;
          bank_d  = BSEL_W'(bank_index(a, BANK_SEL_LSB, BANKS));
          widx_d  = BANK_AW'(word_index(a, BANK_AW));
          rw_d    = rw;
          burst_d = burst;
          be_d    = be;
        end
      end
      WAIT: begin
        if (!strobe)                                  state_d = IDLE;
        else if (wait_q == WCNT_W'(WAIT_CYCLES - 1))  state_d = BEAT;
        else                                          wait_d  = wait_q + 1'b1;
      end
      BEAT: begin
        if (!strobe || !burst_q || beat_q == BEAT_W'(BURST_LEN - 1)) state_d = IDLE;
        else                                                         beat_d  = beat_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) begin
      wait_d = '0;
      beat_d = '0;
    end
  end

  assign ready = (state_q == BEAT);
  assign busy  = (state_q != IDLE);

  // Reads look one beat ahead so the synchronous RAM output lines up with ready;
  // writes address the current beat and commit on the edge that ends it.
  logic [BANK_AW-1:0] beat_off, ram_addr;
  always_comb begin
    beat_off = BANK_AW'(beat_q);
    if (state_q == BEAT && !rw_q) beat_off = beat_off + 1'b1;
    ram_addr = (widx_q & ~BMASK) | ((widx_q + beat_off) & BMASK);
  end

  // A beat whose closing edge sees strobe low is treated as aborted, not written.
  logic wr_commit;
  assign wr_commit = ready && rw_q && strobe;

  logic [DATA_W-1:0] rdata [BANKS];
  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    mem_bank_ram #(
      .DATA_W (DATA_W),
      .AW     (BANK_AW)
    ) u_ram (
      .clk     (clk),
      .we_i    (wr_commit && (bank_q == BSEL_W'(b))),
      .be_i    (be_q),
      .addr_i  (ram_addr),
      .wdata_i (din),
      .rdata_o (rdata[b])
    );
  end

  assign dout = ready ? rdata[bank_q] : '0;

endmodule
